// File: rtl/toggle_handshake_rx_pkg.sv
// Shared types and constants for the toggle-handshake receiver.
package toggle_handshake_rx_pkg;

  localparam int unsigned DATA_W_DEFAULT  = 8;
  localparam int unsigned SYNC_STAGES_MIN = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_e;

endpackage : toggle_handshake_rx_pkg

// File: rtl/sync_bit_chain.sv
// Single-bit async-reset synchroniser chain; bit 0 samples the foreign-domain input.
module sync_bit_chain
  import toggle_handshake_rx_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : sync_bit_chain

// File: rtl/toggle_handshake_rx.sv
// Receive side of a two-phase toggle handshake: each request level change becomes one
// word on a valid/ready port, and each consumed word flips the ack toggle back.
module toggle_handshake_rx
  import toggle_handshake_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  input  logic              clear_ovr_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_tgl_o,
  output logic              overrun_o
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $error("toggle_handshake_rx: SYNC_STAGES must be at least SYNC_STAGES_MIN");
  end

  logic              req_sync;
  logic              prev_q;
  logic              req_edge_c;
  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ack_q, ack_d;
  logic              ovr_q, ovr_d;

  sync_bit_chain #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (req_tgl_i),
    .q_o   (req_sync)
  );

  // Either polarity of the synchronised toggle marks one new word.
  assign req_edge_c = req_sync ^ prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= req_sync;
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    ack_d   = ack_q;
    ovr_d   = ovr_q;

    case (state_q)
      ST_IDLE: begin
        if (req_edge_c) begin
          data_d  = data_i;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (ready_i) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // A request arriving while a word is still held is dropped but remembered; set beats clear.
    if ((state_q == ST_VALID) && req_edge_c) begin
      ovr_d = 1'b1;
    end else if (clear_ovr_i) begin
      ovr_d = 1'b0;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign ack_tgl_o = ack_q;
  assign overrun_o = ovr_q;

endmodule : toggle_handshake_rx

// File: tb/tb_toggle_handshake_rx.sv
// Bench for toggle_handshake_rx: directed scenarios plus random traffic against a transaction-level model.
module tb_toggle_handshake_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_tgl;
  logic [DW-1:0] data;
  logic          ready;
  logic          clr_ovr;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ack_tgl_o;
  logic          overrun_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: toggle history (index 0 = value seen at the latest edge) and transaction state
  bit          hist [0:7];
  bit          m_pend;
  bit [DW-1:0] m_data;
  bit          m_ack;
  bit          m_ovr;

  bit          tx_lvl;
  bit [DW-1:0] tx_data;

  toggle_handshake_rx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_tgl_i   (req_tgl),
    .data_i      (data),
    .ready_i     (ready),
    .clear_ovr_i (clr_ovr),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ack_tgl_o   (ack_tgl_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) hist[i] = 1'b0;
    m_pend = 1'b0;
    m_data = '0;
    m_ack  = 1'b0;
    m_ovr  = 1'b0;
  endtask

  // A toggle becomes visible to the receiver SS edges after it is first sampled.
  task automatic model_edge(input bit rq, input bit [DW-1:0] d, input bit rdy, input bit clr);
    bit ev;
    bit ovr_n;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = rq;
    ev    = (hist[SS] != hist[SS+1]);
    ovr_n = (m_pend && ev) ? 1'b1 : (clr ? 1'b0 : m_ovr);
    if (m_pend) begin
      if (rdy) begin
        m_pend = 1'b0;
        m_ack  = ~m_ack;
      end
    end else if (ev) begin
      m_pend = 1'b1;
      m_data = d;
    end
    m_ovr = ovr_n;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".valid"},   32'(valid_o),   32'(m_pend));
    check({tag, ".data"},    32'(data_o),    32'(m_data));
    check({tag, ".ack"},     32'(ack_tgl_o), 32'(m_ack));
    check({tag, ".overrun"}, 32'(overrun_o), 32'(m_ovr));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare on the falling edge.
  task automatic cycle(input bit rq, input bit [DW-1:0] d, input bit rdy, input bit clr,
                       input string tag);
    req_tgl = rq;
    data    = d;
    ready   = rdy;
    clr_ovr = clr;
    @(posedge clk);
    model_edge(rq, d, rdy, clr);
    @(negedge clk);
    check_outs(tag);
  endtask

  initial begin
    int unsigned flips;
    bit          ack_seen;
    bit          done;

    reset   = 1'b1;
    req_tgl = 1'b0;
    data    = '0;
    ready   = 1'b0;
    clr_ovr = 1'b0;
    tx_lvl  = 1'b0;
    tx_data = '0;
    model_reset();

    // 1: reset held with random inputs, then idle
    for (int i = 0; i < 5; i++)
      cycle(1'($urandom), DW'($urandom), 1'($urandom), 1'($urandom), "t1_rst");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'($urandom), 1'b0, "t1_idle");
    check("t1.valid_low", 32'(valid_o), 32'd0);
    check("t1.ack_low",   32'(ack_tgl_o), 32'd0);

    // 2: rising toggle, consumer ready; valid appears on the third edge
    tx_lvl  = 1'b1;
    tx_data = 8'hA5;
    cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t2");
    cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t2");
    check("t2.not_yet", 32'(valid_o), 32'd0);
    cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t2");
    check("t2.valid_3", 32'(valid_o), 32'd1);
    check("t2.data_a5", 32'(data_o), 32'hA5);
    cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t2");
    check("t2.drop",    32'(valid_o), 32'd0);
    check("t2.ack_1",   32'(ack_tgl_o), 32'd1);

    // 3: falling toggle, consumer stalls
    tx_lvl  = 1'b0;
    tx_data = 8'h3C;
    for (int i = 0; i < 8; i++) cycle(tx_lvl, tx_data, 1'b0, 1'b0, "t3_stall");
    check("t3.held_valid", 32'(valid_o), 32'd1);
    check("t3.held_data",  32'(data_o), 32'h3C);
    check("t3.ack_steady", 32'(ack_tgl_o), 32'd1);
    cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t3_take");
    check("t3.ack_0",      32'(ack_tgl_o), 32'd0);
    check("t3.drop",       32'(valid_o), 32'd0);

    // 4: back-to-back words, second toggle issued as soon as the ack flips
    flips = 0;
    for (int w = 0; w < 2; w++) begin
      tx_lvl   = ~tx_lvl;
      tx_data  = (w == 0) ? 8'h10 : 8'h11;
      ack_seen = ack_tgl_o;
      done     = 1'b0;
      for (int i = 0; i < 12 && !done; i++) begin
        cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t4");
        if (ack_tgl_o != ack_seen) begin
          flips++;
          done = 1'b1;
        end
      end
      if (!done) check("t4.ack_timeout", 32'd0, 32'd1);
    end
    for (int i = 0; i < 3; i++) cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t4_tail");
    check("t4.flips", 32'(flips), 32'd2);
    check("t4.ack",   32'(ack_tgl_o), 32'd0);
    check("t4.data",  32'(data_o), 32'h11);

    // 5: overrun, clear, and clear colliding with a new overrun
    tx_lvl  = ~tx_lvl;
    tx_data = 8'h55;
    for (int i = 0; i < 4; i++) cycle(tx_lvl, tx_data, 1'b0, 1'b0, "t5");
    tx_lvl  = ~tx_lvl;
    tx_data = 8'hAA;
    for (int i = 0; i < 4; i++) cycle(tx_lvl, tx_data, 1'b0, 1'b0, "t5");
    check("t5.ovr_set",  32'(overrun_o), 32'd1);
    check("t5.data_55",  32'(data_o), 32'h55);
    cycle(tx_lvl, tx_data, 1'b0, 1'b1, "t5_clr");
    check("t5.ovr_clr",  32'(overrun_o), 32'd0);
    tx_lvl  = ~tx_lvl;
    tx_data = 8'h99;
    cycle(tx_lvl, tx_data, 1'b0, 1'b0, "t5");
    cycle(tx_lvl, tx_data, 1'b0, 1'b0, "t5");
    cycle(tx_lvl, tx_data, 1'b0, 1'b1, "t5_collide");
    check("t5.set_wins", 32'(overrun_o), 32'd1);
    for (int i = 0; i < 3; i++) cycle(tx_lvl, tx_data, 1'b1, 1'(i == 2), "t5_drain");
    check("t5.ack_1",    32'(ack_tgl_o), 32'd1);

    // 6: reset while a word is pending, then a fresh transfer
    tx_lvl  = ~tx_lvl;
    tx_data = 8'h66;
    for (int i = 0; i < 4; i++) cycle(tx_lvl, tx_data, 1'b0, 1'b0, "t6");
    check("t6.pending", 32'(valid_o), 32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check("t6.rst_valid", 32'(valid_o), 32'd0);
    check("t6.rst_ack",   32'(ack_tgl_o), 32'd0);
    tx_lvl = 1'b0;
    for (int i = 0; i < 2; i++) cycle(tx_lvl, tx_data, 1'b0, 1'b0, "t6_rst");
    reset   = 1'b0;
    tx_lvl  = 1'b1;
    tx_data = 8'h7E;
    for (int i = 0; i < 5; i++) cycle(tx_lvl, tx_data, 1'b1, 1'b0, "t6_after");
    check("t6.data_7e", 32'(data_o), 32'h7E);
    check("t6.ack_1",   32'(ack_tgl_o), 32'd1);

    // Random traffic: toggles, stalls and clears at arbitrary times
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin
        tx_lvl  = ~tx_lvl;
        tx_data = DW'($urandom);
      end
      cycle(tx_lvl, tx_data, 1'($urandom_range(2) != 0), 1'($urandom_range(15) == 0), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_toggle_handshake_rx
